// File: rtl/xadac_pkg.sv
// rtl/xadac_pkg.sv - shared widths, types and entry states for the xadac vector store unit
package xadac_pkg;

    localparam int IdWidth   = 3;
    localparam int AddrWidth = 32;
    localparam int VecWidth  = 64;
    localparam int ImmWidth  = 12;
    localparam int NoEntries = 2 ** IdWidth;
    localparam int BeWidth   = VecWidth / 8;

    typedef logic [IdWidth-1:0]   IdT;
    typedef logic [AddrWidth-1:0] AddrT;
    typedef logic [VecWidth-1:0]  VectorT;
    typedef logic [ImmWidth-1:0]  ImmT;
    typedef logic [BeWidth-1:0]   BeT;

    // Lifecycle of one scoreboard entry:
    // FREE -> PEND_A (accepted) -> WAIT_R (granted) -> DONE (write acked) -> FREE (response taken)
    typedef enum logic [1:0] {
        VS_FREE   = 2'd0,
        VS_PEND_A = 2'd1,
        VS_WAIT_R = 2'd2,
        VS_DONE   = 2'd3
    } vstore_state_e;

    // Effective address: base plus sign-extended immediate, wrapping at AddrWidth bits.
    function automatic AddrT vstore_addr(input AddrT rs1, input ImmT imm);
        return rs1 + {{(AddrWidth-ImmWidth){imm[ImmWidth-1]}}, imm};
    endfunction

endpackage

// File: rtl/xadac_vstore_unit_if.sv
// rtl/xadac_vstore_unit_if.sv - execute-channel request/response and OBI write bundle
// master: execute stage plus OBI slave side (drives req_*, resp_ready, obi_gnt/rvalid/rid/err)
// slave : the store unit (drives req_ready, resp_*, obi_req/addr/we/be/wdata/aid/rready)
interface xadac_vstore_unit_if;
    import xadac_pkg::*;

    logic        req_valid;
    logic        req_ready;
    IdT          req_id;
    AddrT        req_rs1;
    ImmT         req_imm;
    VectorT      req_vs;

    logic        resp_valid;
    logic        resp_ready;
    IdT          resp_id;
    VectorT      resp_vd;
    logic [31:0] resp_rd;

    logic        obi_req;
    logic        obi_gnt;
    AddrT        obi_addr;
    logic        obi_we;
    BeT          obi_be;
    VectorT      obi_wdata;
    IdT          obi_aid;
    logic        obi_rvalid;
    logic        obi_rready;
    IdT          obi_rid;
    logic        obi_err;

    modport master (
        output req_valid, req_id, req_rs1, req_imm, req_vs, resp_ready,
               obi_gnt, obi_rvalid, obi_rid, obi_err,
        input  req_ready, resp_valid, resp_id, resp_vd, resp_rd,
               obi_req, obi_addr, obi_we, obi_be, obi_wdata, obi_aid, obi_rready
    );

    modport slave (
        input  req_valid, req_id, req_rs1, req_imm, req_vs, resp_ready,
               obi_gnt, obi_rvalid, obi_rid, obi_err,
        output req_ready, resp_valid, resp_id, resp_vd, resp_rd,
               obi_req, obi_addr, obi_we, obi_be, obi_wdata, obi_aid, obi_rready
    );

endinterface

// File: rtl/xadac_prio_pick.sv
// rtl/xadac_prio_pick.sv - lowest-index picker: req[N] in; onehot, encoded idx and valid out
module xadac_prio_pick #(
    parameter  int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         valid
);

    assign valid  = |req;
    // Two's-complement trick isolates the lowest set bit.
    assign onehot = req & (~req + N'(1));

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/xadac_vstore_unit.sv
// rtl/xadac_vstore_unit.sv - vector store unit: tagged requests -> one OBI write each -> per-ID completion
// Ports: clk, rstn (async active-low), bus (xadac_vstore_unit_if.slave: req_*, resp_*, obi_*)
module xadac_vstore_unit
    import xadac_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    xadac_vstore_unit_if.slave   bus
);

    vstore_state_e state_q [NoEntries];
    vstore_state_e state_d [NoEntries];
    AddrT          addr_q  [NoEntries];
    VectorT        data_q  [NoEntries];

    logic   obi_req_q;
    AddrT   obi_addr_q;
    VectorT obi_wdata_q;
    IdT     obi_aid_q;
    logic   resp_valid_q;
    IdT     resp_id_q;

    logic   req_hs, gnt_hs, resp_hs;
    AddrT   req_addr;
    AddrT   issue_addr;
    VectorT issue_wdata;

    logic [NoEntries-1:0] pend_mask, done_mask;
    logic [NoEntries-1:0] unused_pend_onehot, unused_done_onehot;
    logic                 pend_valid, done_valid;
    IdT                   pend_idx, done_idx;
    logic                 unused_obi_err;

    // Bus errors have no exception path; the write simply completes.
    assign unused_obi_err = bus.obi_err;

    assign req_addr      = vstore_addr(bus.req_rs1, bus.req_imm);
    assign bus.req_ready = (state_q[bus.req_id] == VS_FREE);
    assign req_hs        = bus.req_valid && bus.req_ready;
    assign gnt_hs        = obi_req_q && bus.obi_gnt;
    assign resp_hs       = resp_valid_q && bus.resp_ready;

    assign bus.obi_req    = obi_req_q;
    assign bus.obi_addr   = obi_addr_q;
    assign bus.obi_wdata  = obi_wdata_q;
    assign bus.obi_aid    = obi_aid_q;
    assign bus.obi_we     = 1'b1;
    assign bus.obi_be     = '1;
    assign bus.obi_rready = 1'b1;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_vd    = '0;
    assign bus.resp_rd    = '0;

    // Entry transitions for this cycle. A response in the grant cycle for the
    // same ID skips WAIT_R; a response for an entry not in WAIT_R is dropped.
    always_comb begin
        for (int i = 0; i < NoEntries; i++) begin
            state_d[i] = state_q[i];
        end
        if (gnt_hs) begin
            state_d[obi_aid_q] = (bus.obi_rvalid && bus.obi_rid == obi_aid_q) ? VS_DONE : VS_WAIT_R;
        end
        if (bus.obi_rvalid && state_q[bus.obi_rid] == VS_WAIT_R) begin
            state_d[bus.obi_rid] = VS_DONE;
        end
        if (resp_hs) begin
            state_d[resp_id_q] = VS_FREE;
        end
        if (req_hs) begin
            state_d[bus.req_id] = VS_PEND_A;
        end
    end

    // Both arbiters look at next-cycle state so a just-granted or just-retired
    // entry is never re-picked and a just-accepted one can issue immediately.
    always_comb begin
        for (int i = 0; i < NoEntries; i++) begin
            pend_mask[i] = (state_d[i] == VS_PEND_A);
            done_mask[i] = (state_d[i] == VS_DONE);
        end
    end

    xadac_prio_pick #(.N(NoEntries)) u_pick_pend (
        .req    (pend_mask),
        .onehot (unused_pend_onehot),
        .idx    (pend_idx),
        .valid  (pend_valid)
    );

    xadac_prio_pick #(.N(NoEntries)) u_pick_done (
        .req    (done_mask),
        .onehot (unused_done_onehot),
        .idx    (done_idx),
        .valid  (done_valid)
    );

    // The entry storage is written on the same edge, so a request being
    // accepted now must forward its address/data straight onto the A channel.
    always_comb begin
        issue_addr  = addr_q[pend_idx];
        issue_wdata = data_q[pend_idx];
        if (req_hs && bus.req_id == pend_idx) begin
            issue_addr  = req_addr;
            issue_wdata = bus.req_vs;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NoEntries; i++) begin
                state_q[i] <= VS_FREE;
            end
            obi_req_q    <= 1'b0;
            obi_addr_q   <= '0;
            obi_wdata_q  <= '0;
            obi_aid_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
        end else begin
            for (int i = 0; i < NoEntries; i++) begin
                state_q[i] <= state_d[i];
            end
            // A channel only reloads when idle or when the current beat is granted.
            if (!obi_req_q || bus.obi_gnt) begin
                obi_req_q <= pend_valid;
                if (pend_valid) begin
                    obi_addr_q  <= issue_addr;
                    obi_wdata_q <= issue_wdata;
                    obi_aid_q   <= pend_idx;
                end
            end
            if (!resp_valid_q || bus.resp_ready) begin
                resp_valid_q <= done_valid;
                if (done_valid) begin
                    resp_id_q <= done_idx;
                end
            end
        end
    end

    // Payload storage needs no reset: it is only read for entries that were written.
    always_ff @(posedge clk) begin
        if (req_hs) begin
            addr_q[bus.req_id] <= req_addr;
            data_q[bus.req_id] <= bus.req_vs;
        end
    end

endmodule

// File: tb/tb_xadac_vstore_unit.sv
// tb/tb_xadac_vstore_unit.sv - self-checking bench for xadac_vstore_unit
module tb_xadac_vstore_unit;
    import xadac_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    xadac_vstore_unit_if bus ();

    xadac_vstore_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Per-ID lifecycle: 0 idle, 1 accepted/not yet granted, 2 granted, 3 acked/awaiting response
    int     mstate [NoEntries];
    AddrT   maddr  [NoEntries];
    VectorT mdata  [NoEntries];

    function automatic AddrT ref_addr(input AddrT rs1, input ImmT imm);
        int off;
        off = $signed(imm);
        return rs1 + AddrT'(off);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid  = 1'b0;
        bus.req_id     = '0;
        bus.req_rs1    = '0;
        bus.req_imm    = '0;
        bus.req_vs     = '0;
        bus.resp_ready = 1'b0;
        bus.obi_gnt    = 1'b0;
        bus.obi_rvalid = 1'b0;
        bus.obi_rid    = '0;
        bus.obi_err    = 1'b0;
    endtask

    task automatic drive_req(input IdT id, input AddrT rs1, input ImmT imm, input VectorT vs);
        bus.req_valid = 1'b1;
        bus.req_id    = id;
        bus.req_rs1   = rs1;
        bus.req_imm   = imm;
        bus.req_vs    = vs;
    endtask

    task automatic send_rvalid(input IdT id);
        bus.obi_rvalid = 1'b1;
        bus.obi_rid    = id;
        tick();
        bus.obi_rvalid = 1'b0;
    endtask

    task automatic wait_resp(input IdT id);
        bit got;
        got = 0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.resp_valid === 1'b1) begin
                got = 1;
                vectors++;
                if (bus.resp_id !== id) begin
                    miscompares++;
                    $display("FAIL wait_resp_id: got %0d want %0d", bus.resp_id, id);
                end
            end
            tick();
        end
        bus.resp_ready = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL wait_resp_timeout: no response for id %0d within 20 cycles", id);
        end
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b0;
        #12;
        vectors++; if (bus.obi_req !== 1'b0)      begin miscompares++; $display("FAIL reset_obi_req: got %0h want 0", bus.obi_req); end
        vectors++; if (bus.resp_valid !== 1'b0)   begin miscompares++; $display("FAIL reset_resp_valid: got %0h want 0", bus.resp_valid); end
        vectors++; if (bus.resp_id !== '0)        begin miscompares++; $display("FAIL reset_resp_id: got %0h want 0", bus.resp_id); end
        vectors++; if (bus.obi_addr !== '0)       begin miscompares++; $display("FAIL reset_obi_addr: got %0h want 0", bus.obi_addr); end
        vectors++; if (bus.obi_wdata !== '0)      begin miscompares++; $display("FAIL reset_obi_wdata: got %0h want 0", bus.obi_wdata); end
        vectors++; if (bus.obi_aid !== '0)        begin miscompares++; $display("FAIL reset_obi_aid: got %0h want 0", bus.obi_aid); end
        vectors++; if (bus.obi_we !== 1'b1)       begin miscompares++; $display("FAIL tie_obi_we: got %0h want 1", bus.obi_we); end
        vectors++; if (bus.obi_be !== 8'hFF)      begin miscompares++; $display("FAIL tie_obi_be: got %0h want ff", bus.obi_be); end
        vectors++; if (bus.obi_rready !== 1'b1)   begin miscompares++; $display("FAIL tie_obi_rready: got %0h want 1", bus.obi_rready); end
        vectors++; if (bus.resp_vd !== '0 || bus.resp_rd !== '0) begin miscompares++; $display("FAIL tie_resp_data: got %0h/%0h want 0/0", bus.resp_vd, bus.resp_rd); end
        for (int i = 0; i < NoEntries; i++) begin
            bus.req_id = IdT'(i);
            #1;
            vectors++;
            if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready[%0d]: got %0h want 1", i, bus.req_ready); end
        end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        VectorT vs;
        vs = 64'hDEADBEEF_CAFEF00D;
        drive_req(3'd2, 32'h0000_1000, 12'hFF8, vs);
        bus.obi_gnt = 1'b1;
        #1;
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL single_req_ready: got %0h want 1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        vectors++; if (bus.obi_req !== 1'b1)             begin miscompares++; $display("FAIL single_obi_req: got %0h want 1", bus.obi_req); end
        vectors++; if (bus.obi_addr !== 32'h0000_0FF8)   begin miscompares++; $display("FAIL single_obi_addr: got %0h want ff8", bus.obi_addr); end
        vectors++; if (bus.obi_wdata !== vs)             begin miscompares++; $display("FAIL single_obi_wdata: got %0h want %0h", bus.obi_wdata, vs); end
        vectors++; if (bus.obi_aid !== 3'd2)             begin miscompares++; $display("FAIL single_obi_aid: got %0d want 2", bus.obi_aid); end
        vectors++; if (bus.obi_be !== 8'hFF)             begin miscompares++; $display("FAIL single_obi_be: got %0h want ff", bus.obi_be); end
        tick();
        bus.obi_gnt    = 1'b0;
        bus.obi_rvalid = 1'b1;
        bus.obi_rid    = 3'd2;
        vectors++; if (bus.obi_req !== 1'b0)    begin miscompares++; $display("FAIL single_obi_drop: got %0h want 0", bus.obi_req); end
        vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL single_resp_early: got %0h want 0", bus.resp_valid); end
        tick();
        bus.obi_rvalid = 1'b0;
        vectors++; if (bus.resp_valid !== 1'b1) begin miscompares++; $display("FAIL single_resp_valid: got %0h want 1", bus.resp_valid); end
        vectors++; if (bus.resp_id !== 3'd2)     begin miscompares++; $display("FAIL single_resp_id: got %0d want 2", bus.resp_id); end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        bus.req_id     = 3'd2;
        #1;
        vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL single_resp_drop: got %0h want 0", bus.resp_valid); end
        vectors++; if (bus.req_ready !== 1'b1)  begin miscompares++; $display("FAIL single_freed: got %0h want 1", bus.req_ready); end
        tick();
    endtask

    task automatic test_backpressure();
        AddrT rs1; ImmT imm; VectorT vs; AddrT ea;
        rs1 = $urandom; imm = ImmT'($urandom); vs = {$urandom, $urandom};
        ea  = ref_addr(rs1, imm);
        drive_req(3'd4, rs1, imm, vs);
        tick();
        bus.req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (bus.obi_req !== 1'b1 || bus.obi_addr !== ea || bus.obi_wdata !== vs || bus.obi_aid !== 3'd4) begin
                miscompares++;
                $display("FAIL bp_stable c%0d: got req=%0h addr=%0h data=%0h aid=%0d want 1/%0h/%0h/4", c, bus.obi_req, bus.obi_addr, bus.obi_wdata, bus.obi_aid, ea, vs);
            end
            tick();
        end
        bus.obi_gnt = 1'b1;
        vectors++; if (bus.obi_req !== 1'b1) begin miscompares++; $display("FAIL bp_grant_req: got %0h want 1", bus.obi_req); end
        tick();
        bus.obi_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (bus.obi_req !== 1'b0) begin miscompares++; $display("FAIL bp_single_write c%0d: got %0h want 0", c, bus.obi_req); end
            tick();
        end
        send_rvalid(3'd4);
        wait_resp(3'd4);
    endtask

    task automatic test_out_of_order();
        AddrT   ea [3];
        VectorT ed [3];
        int     seen [NoEntries];
        int     order [3] = '{2, 0, 1};
        int     gcount;
        AddrT   rs1; ImmT imm;
        gcount = 0;
        for (int i = 0; i < NoEntries; i++) seen[i] = 0;
        bus.obi_gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                rs1 = $urandom; imm = ImmT'($urandom); ed[c] = {$urandom, $urandom};
                ea[c] = ref_addr(rs1, imm);
                drive_req(IdT'(c), rs1, imm, ed[c]);
            end else begin
                bus.req_valid = 1'b0;
            end
            if (bus.obi_req === 1'b1 && gcount < 3) begin
                vectors++;
                if (bus.obi_aid !== IdT'(gcount) || bus.obi_addr !== ea[gcount] || bus.obi_wdata !== ed[gcount]) begin
                    miscompares++;
                    $display("FAIL ooo_issue%0d: got aid=%0d addr=%0h want aid=%0d addr=%0h", gcount, bus.obi_aid, bus.obi_addr, gcount, ea[gcount]);
                end
                gcount++;
            end
            tick();
        end
        bus.obi_gnt = 1'b0;
        vectors++; if (gcount != 3) begin miscompares++; $display("FAIL ooo_issue_count: got %0d want 3", gcount); end
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 3) begin
                bus.obi_rvalid = 1'b1;
                bus.obi_rid    = IdT'(order[c]);
            end else begin
                bus.obi_rvalid = 1'b0;
            end
            if (bus.resp_valid === 1'b1) seen[bus.resp_id]++;
            tick();
        end
        bus.resp_ready = 1'b0;
        for (int i = 0; i < NoEntries; i++) begin
            vectors++;
            if (seen[i] != ((i < 3) ? 1 : 0)) begin miscompares++; $display("FAIL ooo_resp_count[%0d]: got %0d want %0d", i, seen[i], (i < 3) ? 1 : 0); end
        end
        for (int i = 0; i < 3; i++) begin
            bus.req_id = IdT'(i);
            #1;
            vectors++;
            if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL ooo_freed[%0d]: got %0h want 1", i, bus.req_ready); end
        end
        tick();
    endtask

    task automatic test_blocked();
        VectorT vs2;
        vs2 = {$urandom, $urandom};
        drive_req(3'd5, $urandom, ImmT'($urandom), {$urandom, $urandom});
        tick();
        bus.req_valid = 1'b0;
        bus.obi_gnt   = 1'b1;
        tick();
        bus.obi_gnt = 1'b0;
        drive_req(3'd5, 32'h0000_2000, 12'h010, vs2);
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL blocked_ready c%0d: got %0h want 0", c, bus.req_ready); end
            tick();
        end
        bus.obi_rvalid = 1'b1;
        bus.obi_rid    = 3'd5;
        #1;
        vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL blocked_ready_ack: got %0h want 0", bus.req_ready); end
        tick();
        bus.obi_rvalid = 1'b0;
        vectors++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 3'd5) begin miscompares++; $display("FAIL blocked_resp: got v=%0h id=%0d want 1/5", bus.resp_valid, bus.resp_id); end
        vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL blocked_ready_done: got %0h want 0", bus.req_ready); end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        #1;
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL blocked_release: got %0h want 1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        vectors++;
        if (bus.obi_req !== 1'b1 || bus.obi_aid !== 3'd5 || bus.obi_wdata !== vs2 || bus.obi_addr !== 32'h0000_2010) begin
            miscompares++;
            $display("FAIL blocked_reissue: got req=%0h aid=%0d addr=%0h want 1/5/2010", bus.obi_req, bus.obi_aid, bus.obi_addr);
        end
        bus.obi_gnt = 1'b1;
        tick();
        bus.obi_gnt = 1'b0;
        send_rvalid(3'd5);
        wait_resp(3'd5);
    endtask

    task automatic test_zero_latency();
        drive_req(3'd6, $urandom, ImmT'($urandom), {$urandom, $urandom});
        tick();
        bus.req_valid  = 1'b0;
        bus.obi_gnt    = 1'b1;
        bus.obi_rvalid = 1'b1;
        bus.obi_rid    = bus.obi_aid;
        vectors++; if (bus.obi_req !== 1'b1 || bus.obi_aid !== 3'd6) begin miscompares++; $display("FAIL zl_issue: got req=%0h aid=%0d want 1/6", bus.obi_req, bus.obi_aid); end
        tick();
        bus.obi_gnt    = 1'b0;
        bus.obi_rvalid = 1'b0;
        vectors++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 3'd6) begin miscompares++; $display("FAIL zl_resp: got v=%0h id=%0d want 1/6", bus.resp_valid, bus.resp_id); end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL zl_resp_once: got %0h want 0", bus.resp_valid); end
    endtask

    task automatic test_random();
        IdT     issued [$];
        bit     stall_prev, drain;
        AddrT   p_addr;
        IdT     p_aid;
        VectorT p_data;
        int     k, accepted, completed;
        stall_prev = 0; accepted = 0; completed = 0;
        p_addr = '0; p_aid = '0; p_data = '0;
        for (int i = 0; i < NoEntries; i++) mstate[i] = 0;
        for (int cyc = 0; cyc < 2300; cyc++) begin
            drain = (cyc >= 2000);
            if (stall_prev) begin
                vectors++;
                if (bus.obi_req !== 1'b1 || bus.obi_aid !== p_aid || bus.obi_addr !== p_addr || bus.obi_wdata !== p_data) begin
                    miscompares++;
                    $display("FAIL rnd_stall_stable cyc%0d: got req=%0h aid=%0d addr=%0h want 1/%0d/%0h", cyc, bus.obi_req, bus.obi_aid, bus.obi_addr, p_aid, p_addr);
                end
            end
            if (bus.obi_req === 1'b1) begin
                vectors++;
                if (mstate[bus.obi_aid] != 1 || bus.obi_addr !== maddr[bus.obi_aid] || bus.obi_wdata !== mdata[bus.obi_aid]) begin
                    miscompares++;
                    $display("FAIL rnd_issue cyc%0d: aid=%0d state=%0d addr=%0h data=%0h want state 1 addr=%0h data=%0h", cyc, bus.obi_aid, mstate[bus.obi_aid], bus.obi_addr, bus.obi_wdata, maddr[bus.obi_aid], mdata[bus.obi_aid]);
                end
            end
            if (bus.resp_valid === 1'b1) begin
                vectors++;
                if (mstate[bus.resp_id] != 3) begin
                    miscompares++;
                    $display("FAIL rnd_resp cyc%0d: id=%0d state=%0d want 3", cyc, bus.resp_id, mstate[bus.resp_id]);
                end
            end
            bus.obi_gnt = bus.obi_req && (drain || $urandom_range(0, 2) != 0);
            issued.delete();
            for (int i = 0; i < NoEntries; i++) if (mstate[i] == 2) issued.push_back(IdT'(i));
            bus.obi_rvalid = 1'b0;
            if (issued.size() > 0 && (drain || $urandom_range(0, 1) == 1)) begin
                bus.obi_rvalid = 1'b1;
                bus.obi_rid    = issued[$urandom_range(0, issued.size() - 1)];
            end else if (bus.obi_gnt && $urandom_range(0, 3) == 0) begin
                bus.obi_rvalid = 1'b1;
                bus.obi_rid    = bus.obi_aid;
            end else if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, NoEntries - 1);
                if (mstate[k] == 0) begin
                    bus.obi_rvalid = 1'b1;
                    bus.obi_rid    = IdT'(k);
                end
            end
            bus.resp_ready = drain || $urandom_range(0, 1) == 1;
            bus.req_valid  = !drain && $urandom_range(0, 1) == 1;
            bus.req_id     = IdT'($urandom_range(0, NoEntries - 1));
            bus.req_rs1    = $urandom;
            bus.req_imm    = ImmT'($urandom);
            bus.req_vs     = {$urandom, $urandom};
            #1;
            vectors++;
            if (bus.req_ready !== (mstate[bus.req_id] == 0)) begin
                miscompares++;
                $display("FAIL rnd_req_ready cyc%0d: id=%0d got %0h want %0h", cyc, bus.req_id, bus.req_ready, mstate[bus.req_id] == 0);
            end
            if (bus.obi_rvalid && mstate[bus.obi_rid] == 2) mstate[bus.obi_rid] = 3;
            if (bus.obi_req && bus.obi_gnt) mstate[bus.obi_aid] = (bus.obi_rvalid && bus.obi_rid == bus.obi_aid) ? 3 : 2;
            if (bus.resp_valid && bus.resp_ready) begin
                mstate[bus.resp_id] = 0;
                completed++;
            end
            if (bus.req_valid && bus.req_ready) begin
                mstate[bus.req_id] = 1;
                maddr[bus.req_id]  = ref_addr(bus.req_rs1, bus.req_imm);
                mdata[bus.req_id]  = bus.req_vs;
                accepted++;
            end
            stall_prev = bus.obi_req && !bus.obi_gnt;
            p_addr = bus.obi_addr; p_aid = bus.obi_aid; p_data = bus.obi_wdata;
            tick();
        end
        idle();
        for (int i = 0; i < NoEntries; i++) begin
            vectors++;
            if (mstate[i] != 0) begin miscompares++; $display("FAIL rnd_drained[%0d]: state %0d want 0", i, mstate[i]); end
        end
        vectors++;
        if (accepted != completed || accepted < 50) begin
            miscompares++;
            $display("FAIL rnd_totals: accepted %0d completed %0d want equal and at least 50", accepted, completed);
        end
    endtask

    task automatic test_reset_midflight();
        IdT ids [3] = '{3'd1, 3'd3, 3'd7};
        bus.obi_gnt = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive_req(ids[c], $urandom, ImmT'($urandom), {$urandom, $urandom});
            else bus.req_valid = 1'b0;
            tick();
        end
        bus.obi_gnt = 1'b0;
        #1;
        rstn = 1'b0;
        #1;
        vectors++;
        if (bus.obi_req !== 1'b0 || bus.resp_valid !== 1'b0 || bus.obi_addr !== '0 || bus.obi_wdata !== '0 || bus.obi_aid !== '0 || bus.resp_id !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs: req=%0h rv=%0h addr=%0h data=%0h aid=%0d rid=%0d want all 0", bus.obi_req, bus.resp_valid, bus.obi_addr, bus.obi_wdata, bus.obi_aid, bus.resp_id);
        end
        tick();
        rstn = 1'b1;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c < 3) begin
                bus.obi_rvalid = 1'b1;
                bus.obi_rid    = ids[c];
            end else begin
                bus.obi_rvalid = 1'b0;
            end
            vectors++;
            if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_no_resp c%0d: got %0h want 0", c, bus.resp_valid); end
            tick();
        end
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.req_id = ids[i];
            #1;
            vectors++;
            if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_free[%0d]: got %0h want 1", ids[i], bus.req_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_out_of_order();
        test_blocked();
        test_zero_latency();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
